// File: rtl/axi_sram_read_slave_if.sv
// AXI read-channel bundle (AR + R) between the interconnect and the
// SRAM read slave. The master side drives AR and RREADY; the slave side
// drives ARREADY and the R beat.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where VALID and READY are both high. VALID, once raised, holds its
// payload until that edge. VALID never waits on READY.
interface axi_sram_read_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_sram_read_slave.sv
// AXI read slave in front of a synchronous single-port SRAM.
// Accepts one AR burst at a time (FIXED / INCR / WRAP), streams one R beat
// per cycle by presenting the next beat's word address in the same cycle
// the current beat is accepted. Illegal requests return SLVERR beats
// without touching the SRAM.
// Optional feature macro: AXI_WRAP_BURST_EN (defined = WRAP bursts served,
// undefined = WRAP requests answered with SLVERR).
module axi_sram_read_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14,
  parameter int LEN_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_sram_read_slave_if.slave bus,
  input  logic                 rd_allow,
  output logic                 finish,
  output logic [SRAM_AW-1:0]   Address,
  output logic                 ReadEnable,
  input  logic [DATA_W-1:0]    DataRead,
  output logic                 state_dbg
);

  localparam int OFS = $clog2(DATA_W / 8);

  typedef enum logic {IDLE, DATA} state_t;

  state_t             state;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               err_q;
`ifdef AXI_WRAP_BURST_EN
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  wrap_mask;
`endif

  logic               ar_legal;
  logic               last_beat;
  logic [ADDR_W-1:0]  step;
  logic [ADDR_W-1:0]  aligned;
  logic [ADDR_W-1:0]  next_addr;

  // Legality of the request currently on AR.
  always_comb begin
    ar_legal = 1'b1;
    if (int'(bus.ARSIZE) > OFS) ar_legal = 1'b0;
    if (bus.ARBURST == 2'b11)   ar_legal = 1'b0;
`ifdef AXI_WRAP_BURST_EN
    if (bus.ARBURST == 2'b10 &&
        !(int'(bus.ARLEN) == 1 || int'(bus.ARLEN) == 3 ||
          int'(bus.ARLEN) == 7 || int'(bus.ARLEN) == 15))
      ar_legal = 1'b0;
`else
    if (bus.ARBURST == 2'b10)   ar_legal = 1'b0;
`endif
  end

  // Address of the beat after the current one; stepping starts from the
  // size-aligned address so an unaligned start only affects beat 0.
  always_comb begin
    step    = ADDR_W'(1) << size_q;
    aligned = addr_q & ~(step - ADDR_W'(1));
`ifdef AXI_WRAP_BURST_EN
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
`endif
    case (burst_q)
      2'b01:   next_addr = aligned + step;
`ifdef AXI_WRAP_BURST_EN
      2'b10:   next_addr = (aligned & ~wrap_mask) | ((aligned + step) & wrap_mask);
`endif
      default: next_addr = addr_q;
    endcase
  end

  assign last_beat = (cnt_q == '0);

  // SRAM port: first word on the AR handshake, then lookahead on accept,
  // otherwise hold the current word so RDATA stays stable during a stall.
  always_comb begin
    Address    = '0;
    ReadEnable = 1'b0;
    if (state == IDLE) begin
      if (bus.ARVALID && rd_allow && ar_legal) begin
        Address    = bus.ARADDR[SRAM_AW+OFS-1:OFS];
        ReadEnable = 1'b1;
      end
    end else if (!err_q) begin
      ReadEnable = 1'b1;
      if (bus.RREADY && !last_beat) Address = next_addr[SRAM_AW+OFS-1:OFS];
      else                          Address = addr_q[SRAM_AW+OFS-1:OFS];
    end
  end

  assign bus.ARREADY = (state == IDLE) && rd_allow;
  assign bus.RVALID  = (state == DATA);
  assign bus.RID     = id_q;
  assign bus.RDATA   = (state == DATA && !err_q) ? DataRead : '0;
  assign bus.RRESP   = err_q ? 2'b10 : 2'b00;
  assign bus.RLAST   = (state == DATA) && last_beat;
  assign finish      = (state == DATA) && bus.RREADY && last_beat;
  assign state_dbg   = (state == DATA);

  // Burst FSM: capture AR, count beats down, step the address on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef AXI_WRAP_BURST_EN
      len_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ARVALID && rd_allow) begin
            state   <= DATA;
            id_q    <= bus.ARID;
            addr_q  <= bus.ARADDR;
            size_q  <= bus.ARSIZE;
            burst_q <= bus.ARBURST;
            cnt_q   <= bus.ARLEN;
            err_q   <= !ar_legal;
`ifdef AXI_WRAP_BURST_EN
            len_q   <= bus.ARLEN;
`endif
          end
        end
        DATA: begin
          if (bus.RREADY) begin
            if (last_beat) begin
              state   <= IDLE;
              id_q    <= '0;
              addr_q  <= '0;
              size_q  <= '0;
              burst_q <= '0;
              err_q   <= 1'b0;
`ifdef AXI_WRAP_BURST_EN
              len_q   <= '0;
`endif
            end else begin
              cnt_q  <= cnt_q - LEN_W'(1);
              addr_q <= next_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Bench for axi_sram_read_slave: directed vector table, random bursts,
// mid-burst reset. Expected beats come from an address model built from
// the burst rules with plain arithmetic.
module tb_axi_sram_read_slave;
  localparam int ID_W    = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SRAM_AW = 14;
  localparam int LEN_W   = 4;
  localparam int OFS_TB  = $clog2(DATA_W / 8);

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                rd_allow;
  logic                finish;
  logic [SRAM_AW-1:0]  Address;
  logic                ReadEnable;
  logic [DATA_W-1:0]   DataRead = '0;
  logic                state_dbg;

  int errors = 0;
  int checks = 0;

  // {word[13:0], resp[1:0], last}
  logic [16:0] exp_q[$];

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          rr_mode;
    int          allow_delay;
    int          exp_fin;
    logic [1:0]  exp_resp;
    logic [13:0] exp_word;
  } vec_t;

  vec_t vecs[10];

  axi_sram_read_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  axi_sram_read_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .LEN_W(LEN_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .rd_allow(rd_allow),
    .finish(finish),
    .Address(Address),
    .ReadEnable(ReadEnable),
    .DataRead(DataRead),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SRAM contents: distinct value per word
  function automatic logic [31:0] mem_fn(input logic [13:0] w);
    return {w, 2'b01, ~w, 2'b10} ^ 32'hA5C3_0F1E;
  endfunction

  // synchronous SRAM model: data valid the cycle after the read strobe
  always @(posedge clock) if (ReadEnable) DataRead <= mem_fn(Address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int rr_mode,
                              input int allow_delay, input int exp_fin, input logic [1:0] exp_resp,
                              input logic [13:0] exp_word);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.rr_mode = rr_mode; v.allow_delay = allow_delay; v.exp_fin = exp_fin;
    v.exp_resp = exp_resp; v.exp_word = exp_word;
    return v;
  endfunction

  // reference model: list of beats for one burst
  task automatic build_model(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output logic legal);
    logic [31:0] s, total, aligned, bnd, a;
    int n;
    n = int'(len) + 1;
    legal = (int'(size) <= OFS_TB) && (burst != 2'b11);
    if (burst == 2'b10) begin
`ifdef AXI_WRAP_BURST_EN
      if (!(n == 2 || n == 4 || n == 8 || n == 16)) legal = 1'b0;
`else
      legal = 1'b0;
`endif
    end
    s       = 32'd1 << size;
    total   = s * 32'(n);
    aligned = addr - (addr % s);
    bnd     = aligned - (aligned % total);
    for (int i = 0; i < n; i++) begin
      if (i == 0 || burst == 2'b00) a = addr;
      else if (burst == 2'b01)      a = aligned + s * 32'(i);
      else                          a = bnd + ((aligned - bnd + s * 32'(i)) % total);
      exp_q.push_back({a[15:2], (legal ? 2'b00 : 2'b10), (i == n - 1)});
    end
  endtask

  // driver + scoreboard for one burst; called at posedge+1
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int rr_mode,
                           input int allow_delay, output int fin_at, output logic [1:0] first_resp,
                           output logic [13:0] first_word);
    logic legal;
    logic [16:0] cur;
    int beat, stall, budget;
    exp_q.delete();
    build_model(addr, len, size, burst, legal);
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    rd_allow    = (allow_delay == 0);
    for (int c = 0; c < allow_delay; c++) begin
      @(negedge clock);
      check("arready_blocked", bus.ARREADY, 0);
      check("rvalid_blocked", bus.RVALID, 0);
      @(posedge clock); #1;
    end
    rd_allow = 1'b1;
    @(negedge clock);
    check("arready", bus.ARREADY, 1);
    check("ar_read_enable", ReadEnable, legal);
    if (legal) check("ar_address", Address, exp_q[0][16:3]);
    first_word = Address;
    @(posedge clock); #1;
    bus.ARVALID = 1'b0;
    fin_at = 0; first_resp = 2'b11; beat = 0; stall = 0; budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      budget++;
      case (rr_mode)
        0: bus.RREADY = 1'b1;
        1: bus.RREADY = ($urandom_range(0, 2) != 0);
        default: begin
          if (beat == 1 && stall < 2) begin bus.RREADY = 1'b0; stall++; end
          else bus.RREADY = 1'b1;
        end
      endcase
      @(negedge clock);
      cur = exp_q[0];
      check("rvalid", bus.RVALID, 1);
      check("arready_busy", bus.ARREADY, 0);
      check("rid", bus.RID, id);
      check("rresp", bus.RRESP, cur[2:1]);
      check("rlast", bus.RLAST, cur[0]);
      check("rdata", bus.RDATA, (cur[2:1] == 2'b00) ? mem_fn(cur[16:3]) : 32'h0);
      check("read_enable", ReadEnable, legal);
      if (legal) check("address", Address, (bus.RREADY && !cur[0]) ? exp_q[1][16:3] : cur[16:3]);
      check("finish", finish, bus.RREADY && cur[0]);
      if (bus.RREADY) begin
        if (beat == 0) first_resp = bus.RRESP;
        beat++;
        if (finish && fin_at == 0) fin_at = beat;
        void'(exp_q.pop_front());
      end
      @(posedge clock); #1;
    end
    bus.RREADY = 1'b0;
    check("burst_done", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
    check("arready_after", bus.ARREADY, 1);
    check("rvalid_after", bus.RVALID, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    int fin_at;
    logic [1:0] fresp;
    logic [13:0] fword;
    logic [3:0] rlen;
    logic [1:0] rburst;

    // vector table: id, addr, len, size, burst, rready mode, allow delay,
    // finish beat, first resp, first word
    vecs[0] = mk(8'h01, 32'h0000_0010, 4'd0,  3'd2, 2'b01, 0, 0, 1,  2'b00, 14'd4);
    vecs[1] = mk(8'h02, 32'h0000_0020, 4'd3,  3'd2, 2'b01, 2, 0, 4,  2'b00, 14'd8);
`ifdef AXI_WRAP_BURST_EN
    vecs[2] = mk(8'h03, 32'h0000_0038, 4'd3,  3'd2, 2'b10, 0, 0, 4,  2'b00, 14'd14);
`else
    vecs[2] = mk(8'h03, 32'h0000_0038, 4'd3,  3'd2, 2'b10, 0, 0, 4,  2'b10, 14'd14);
`endif
    vecs[3] = mk(8'h04, 32'h0000_0000, 4'd1,  3'd3, 2'b01, 0, 0, 2,  2'b10, 14'd0);
    vecs[4] = mk(8'h05, 32'h0000_0000, 4'd1,  3'd2, 2'b11, 0, 0, 2,  2'b10, 14'd0);
    vecs[5] = mk(8'h06, 32'h0000_0040, 4'd2,  3'd2, 2'b00, 0, 3, 3,  2'b00, 14'd16);
    vecs[6] = mk(8'h07, 32'h0000_1000, 4'd4,  3'd2, 2'b10, 1, 0, 5,  2'b10, 14'd0);
    vecs[7] = mk(8'h08, 32'h0000_0013, 4'd3,  3'd1, 2'b01, 1, 0, 4,  2'b00, 14'd4);
    vecs[8] = mk(8'h09, 32'h0000_007C, 4'd15, 3'd0, 2'b00, 1, 0, 16, 2'b00, 14'd31);
    vecs[9] = mk(8'h0A, 32'hFFFF_FFF8, 4'd3,  3'd2, 2'b01, 0, 0, 4,  2'b00, 14'h3FFE);

    // reset state
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b0; rd_allow = 1'b1;
    #1;
    check("rst_arready_hi", bus.ARREADY, 1);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_finish", finish, 0);
    check("rst_read_enable", ReadEnable, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rresp", bus.RRESP, 0);
    check("rst_address", Address, 0);
    rd_allow = 1'b0;
    #1;
    check("rst_arready_lo", bus.ARREADY, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                vecs[i].rr_mode, vecs[i].allow_delay, fin_at, fresp, fword);
      check("tbl_finish_beat", fin_at, vecs[i].exp_fin);
      check("tbl_first_resp", fresp, vecs[i].exp_resp);
      if (vecs[i].exp_resp == 2'b00) check("tbl_first_word", fword, vecs[i].exp_word);
    end

    // random bursts
    for (int i = 0; i < 40; i++) begin
      rburst = 2'($urandom_range(0, 3));
      rlen   = 4'($urandom_range(0, 15));
      if (rburst == 2'b10 && $urandom_range(0, 1) == 1) rlen = 4'((1 << $urandom_range(1, 4)) - 1);
      run_burst(8'($urandom), $urandom, rlen, 3'($urandom_range(0, 3)), rburst,
                1, $urandom_range(0, 2), fin_at, fresp, fword);
      check("rnd_finish_beat", fin_at, int'(rlen) + 1);
    end

    // reset during beat 2 of an 8-beat burst
    bus.ARID = 8'h5A; bus.ARADDR = 32'h0000_0100; bus.ARLEN = 4'd7; bus.ARSIZE = 3'd2;
    bus.ARBURST = 2'b01; bus.ARVALID = 1'b1; rd_allow = 1'b1; bus.RREADY = 1'b1;
    @(posedge clock); #1;
    bus.ARVALID = 1'b0;
    @(posedge clock); #1;
    check("mid_rvalid", bus.RVALID, 1);
    check("mid_rdata", bus.RDATA, mem_fn(14'd65));
    #2 reset = 1'b0;
    #1;
    check("mrst_rvalid", bus.RVALID, 0);
    check("mrst_rlast", bus.RLAST, 0);
    check("mrst_finish", finish, 0);
    check("mrst_read_enable", ReadEnable, 0);
    check("mrst_rid", bus.RID, 0);
    check("mrst_rdata", bus.RDATA, 0);
    check("mrst_rresp", bus.RRESP, 0);
    check("mrst_address", Address, 0);
    check("mrst_arready", bus.ARREADY, 1);
    bus.RREADY = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_burst(8'h77, 32'h0000_0200, 4'd2, 3'd2, 2'b01, 0, 0, fin_at, fresp, fword);
    check("post_rst_finish_beat", fin_at, 3);
    check("post_rst_first_word", fword, 14'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
